// File: rtl/dqn_pkg.sv
// dqn_pkg: phase codes and field widths shared by the DQN step sequencer
// and its watchdog.
package dqn_pkg;

  localparam int STATE_W   = 4;
  localparam int STEP_W    = 4;
  localparam int EPISODE_W = 12;
  localparam int PHASE_W   = 3;
  localparam int CTRL_W    = 4;
  localparam int TMO_W     = 8;

  // Phase codes; the controller output carries these values unchanged
  localparam logic [PHASE_W-1:0] PH_IDLE = 3'd0;
  localparam logic [PHASE_W-1:0] PH_FWD  = 3'd1;
  localparam logic [PHASE_W-1:0] PH_ACT  = 3'd2;
  localparam logic [PHASE_W-1:0] PH_BWD  = 3'd3;
  localparam logic [PHASE_W-1:0] PH_UPD  = 3'd4;
  localparam logic [PHASE_W-1:0] PH_NEXT = 3'd5;
  localparam logic [PHASE_W-1:0] PH_DONE = 3'd6;
  localparam logic [PHASE_W-1:0] PH_ERR  = 3'd7;

  // Phases that are part of an active training step
  function automatic logic ph_is_busy(input logic [PHASE_W-1:0] ph);
    return (ph >= PH_FWD) && (ph <= PH_NEXT);
  endfunction

  // Phases that wait on an external done handshake
  function automatic logic ph_is_wait(input logic [PHASE_W-1:0] ph);
    return (ph == PH_FWD) || (ph == PH_ACT) || (ph == PH_BWD);
  endfunction

endpackage

// File: rtl/step_sequencer_watchdog.sv
// phase_watchdog: counts cycles spent in a handshake phase and flags expiry
// once i_limit cycles have been counted without the phase completing.
// i_clear marks the first cycle of a phase; that cycle counts as cycle one.
module phase_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  // One extra bit so the increment can never wrap before the compare
  logic [CNT_W:0] r_cnt;
  logic [CNT_W:0] w_cnt_eff;
  logic [CNT_W:0] w_cnt_inc;

  assign w_cnt_eff = i_clear ? '0 : r_cnt;
  assign w_cnt_inc = w_cnt_eff + {{CNT_W{1'b0}}, 1'b1};
  assign o_expire  = i_enable && (w_cnt_inc >= {1'b0, i_limit});

  // Cycle counter: idle at zero outside phases, holds once expired
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_cnt <= '0;
    else if (!i_enable)   r_cnt <= '0;
    else if (!o_expire)   r_cnt <= w_cnt_inc;
  end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: DQN training step controller. Walks each step through
// forward pass, action select, backward pass, weight update and step
// advance, tracking state / step / episode counters.
// Define DQN_SEQ_TIMEOUT_EN to add a per-phase watchdog that traps to ERR.
import dqn_pkg::*;

module step_sequencer #(
  parameter logic [STATE_W-1:0]   INIT_STATE  = 4'd0,
  parameter logic [STATE_W-1:0]   GOAL_STATE  = 4'd15,
  parameter logic [STEP_W-1:0]    MAX_STEP    = 4'd15,
  parameter logic [EPISODE_W-1:0] MAX_EPISODE = 12'd4095,
  parameter logic [TMO_W-1:0]     TIMEOUT_CYC = 8'd255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STATE_W-1:0]   st1,
  output logic                 fwd_start,
  input  logic                 fwd_done,
  output logic                 act_start,
  input  logic                 act_done,
  output logic                 bwd_start,
  input  logic                 bwd_done,
  output logic                 upd_en,
  output logic [STATE_W-1:0]   st,
  output logic [STEP_W-1:0]    step,
  output logic [EPISODE_W-1:0] episode,
  output logic [CTRL_W-1:0]    controller,
  output logic                 busy,
  output logic                 train_done,
  output logic                 err
);

  logic [PHASE_W-1:0]   r_state;
  logic [PHASE_W-1:0]   w_state_nxt;
  logic                 r_entry;     // first cycle of the current state
  logic [STATE_W-1:0]   r_st;
  logic [STATE_W-1:0]   r_st1_lat;   // next state captured at action select
  logic [STEP_W-1:0]    r_step;
  logic [EPISODE_W-1:0] r_episode;

  logic w_done_sel;
  logic w_done_ok;
  logic w_expire;
  logic w_ep_end;
  logic w_last_ep;
  logic w_run_req;

  // Done of the phase we are in; the entry cycle never completes a phase
  always_comb begin
    w_done_sel = 1'b0;
    case (r_state)
      PH_FWD:  w_done_sel = fwd_done;
      PH_ACT:  w_done_sel = act_done;
      PH_BWD:  w_done_sel = bwd_done;
      default: w_done_sel = 1'b0;
    endcase
  end

  assign w_done_ok = w_done_sel && !r_entry;
  // Goal and step limit together still make a single episode end
  assign w_ep_end  = (r_st1_lat == GOAL_STATE) || (r_step == MAX_STEP);
  assign w_last_ep = (r_episode == MAX_EPISODE);
  assign w_run_req = start && ((r_state == PH_IDLE) || (r_state == PH_DONE));

`ifdef DQN_SEQ_TIMEOUT_EN
  phase_watchdog #(
    .CNT_W    (TMO_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_entry),
    .i_enable (ph_is_wait(r_state)),
    .i_limit  (TIMEOUT_CYC),
    .o_expire (w_expire)
  );
  assign err = (r_state == PH_ERR);
`else
  logic [TMO_W-1:0] w_unused_limit;
  assign w_unused_limit = TIMEOUT_CYC;
  assign w_expire       = 1'b0;
  assign err            = 1'b0;
`endif

  // Next-state decode; a done in the same cycle as expiry wins
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PH_IDLE, PH_DONE: if (w_run_req) w_state_nxt = PH_FWD;
      PH_FWD: begin
        if (w_done_ok)     w_state_nxt = PH_ACT;
        else if (w_expire) w_state_nxt = PH_ERR;
      end
      PH_ACT: begin
        if (w_done_ok)     w_state_nxt = PH_BWD;
        else if (w_expire) w_state_nxt = PH_ERR;
      end
      PH_BWD: begin
        if (w_done_ok)     w_state_nxt = PH_UPD;
        else if (w_expire) w_state_nxt = PH_ERR;
      end
      PH_UPD:  w_state_nxt = PH_NEXT;
      PH_NEXT: w_state_nxt = (w_ep_end && w_last_ep) ? PH_DONE : PH_FWD;
      PH_ERR:  w_state_nxt = PH_ERR;
      default: w_state_nxt = PH_IDLE;
    endcase
  end

  // State register plus entry flag that qualifies start strobes and dones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PH_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_entry <= (w_state_nxt != r_state);
    end
  end

  // Captures the action determiner's next state when ACT completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_st1_lat <= INIT_STATE;
    else if ((r_state == PH_ACT) && w_done_ok) r_st1_lat <= st1;
  end

  // Environment state, step and episode counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= INIT_STATE;
      r_step    <= '0;
      r_episode <= '0;
    end else if (w_run_req) begin
      r_st      <= INIT_STATE;
      r_step    <= '0;
      r_episode <= '0;
    end else if (r_state == PH_NEXT) begin
      if (w_ep_end) begin
        r_st   <= INIT_STATE;
        r_step <= '0;
        // Episode holds at the last index when training finishes
        if (!w_last_ep) r_episode <= r_episode + {{(EPISODE_W-1){1'b0}}, 1'b1};
      end else begin
        r_st   <= r_st1_lat;
        r_step <= r_step + {{(STEP_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fwd_start  = (r_state == PH_FWD) && r_entry;
  assign act_start  = (r_state == PH_ACT) && r_entry;
  assign bwd_start  = (r_state == PH_BWD) && r_entry;
  assign upd_en     = (r_state == PH_UPD);
  assign busy       = ph_is_busy(r_state);
  assign train_done = (r_state == PH_DONE);
  assign controller = {1'b0, r_state};
  assign st         = r_st;
  assign step       = r_step;
  assign episode    = r_episode;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: randomized done handshakes with a scoreboard
// checked at every weight-update strobe, plus directed phase/reset cases.
module tb_step_sequencer;

  localparam logic [3:0]  INIT = 4'd0;
  localparam logic [3:0]  GOAL = 4'd15;
  localparam logic [3:0]  MAXS = 4'd15;
  localparam logic [11:0] MAXE = 12'd1;
  localparam logic [7:0]  TOC  = 8'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  st1 = 4'd0;
  logic        fwd_start, act_start, bwd_start;
  logic        fwd_done = 1'b0, act_done = 1'b0, bwd_done = 1'b0;
  logic        upd_en, busy, train_done, err;
  logic [3:0]  st, step, controller;
  logic [11:0] episode;

  int n_tests = 0;
  int n_fail  = 0;

  step_sequencer #(
    .INIT_STATE (INIT), .GOAL_STATE (GOAL), .MAX_STEP (MAXS),
    .MAX_EPISODE(MAXE), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .st1(st1),
    .fwd_start(fwd_start), .fwd_done(fwd_done),
    .act_start(act_start), .act_done(act_done),
    .bwd_start(bwd_start), .bwd_done(bwd_done),
    .upd_en(upd_en), .st(st), .step(step), .episode(episode),
    .controller(controller), .busy(busy), .train_done(train_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] st; logic [3:0] step; logic [11:0] ep; } exp_t;
  exp_t       q[$];
  logic [3:0]  m_st;
  logic [3:0]  m_step;
  logic [11:0] m_ep;
  bit          m_done;

  task automatic model_reset();
    m_st = INIT; m_step = 0; m_ep = 0; m_done = 0;
  endtask

  // One completed action select: record what the update strobe must show,
  // then advance the environment by the sequencing rules.
  task automatic model_act(input logic [3:0] v);
    exp_t e;
    e.st = m_st; e.step = m_step; e.ep = m_ep;
    q.push_back(e);
    if (v == GOAL || m_step == MAXS) begin
      m_step = 0; m_st = INIT;
      if (m_ep == MAXE) m_done = 1; else m_ep = m_ep + 1;
    end else begin
      m_st = v; m_step = m_step + 1;
    end
  endtask

  // ---------------- responder ----------------
  bit         resp_en = 0;
  int         fixed_delay = 0;
  int         goal_pct = 0;
  logic [3:0] scr[$];

  function automatic logic [3:0] pick();
    if (scr.size() > 0) return scr.pop_front();
    if ($urandom_range(99) < goal_pct) return GOAL;
    return 4'($urandom_range(14));
  endfunction

  initial begin : responder
    int pend = 0;
    int ph = 0;
    logic [3:0] v;
    forever begin
      @(negedge clk);
      if (rst || !resp_en) begin pend = 0; continue; end
      fwd_done = 0; act_done = 0; bwd_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          case (ph)
            1: fwd_done = 1;
            2: begin v = pick(); st1 = v; act_done = 1; model_act(v); end
            default: bwd_done = 1;
          endcase
        end else if ($urandom_range(3) == 0) begin
          // done of a different phase while waiting: must be ignored
          st1 = 4'($urandom);
          case ((ph % 3) + 1)
            1: fwd_done = 1;
            2: act_done = 1;
            default: bwd_done = 1;
          endcase
        end
      end else if (fwd_start || act_start || bwd_start) begin
        ph   = fwd_start ? 1 : (act_start ? 2 : 3);
        pend = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
        if (fixed_delay == 0 && $urandom_range(3) == 0) begin
          // matching done during the entry cycle: must be ignored
          st1 = 4'($urandom);
          case (ph)
            1: fwd_done = 1;
            2: act_done = 1;
            default: bwd_done = 1;
          endcase
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_ctrl", busy, (controller >= 1 && controller <= 5));
      chk("done_vs_ctrl", train_done, (controller == 6));
      chk("err_vs_ctrl", err, (controller == 7));
      if (upd_en) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL upd_unexpected: got upd_en=1 expected no update at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("upd_st", st, e.st);
          chk("upd_step", step, e.step);
          chk("upd_episode", episode, e.ep);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    resp_en = 0;
    fwd_done = 0; act_done = 0; bwd_done = 0; start = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    q.delete();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    model_reset();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int budget, input int inject_at, input string nm);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      start = (k == inject_at);
      @(negedge clk);
      if (train_done === 1'b1) begin ok = 1; break; end
    end
    start = 0;
    chk(nm, ok, 1);
  endtask

  task automatic check_done_state(input string nm);
    chk({nm, "_model_done"}, m_done, 1);
    chk({nm, "_queue_empty"}, q.size(), 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_episode"}, episode, MAXE);
    chk({nm, "_step"}, step, 0);
    chk({nm, "_st"}, st, INIT);
    chk({nm, "_ctrl"}, controller, 6);
  endtask

  initial begin : watchdog_tb
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [3:0] seq [8];
    int n;
    seq = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5};
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_st", st, INIT);
    chk("rst_step", step, 0);
    chk("rst_episode", episode, 0);
    chk("rst_ctrl", controller, 0);
    chk("rst_flags", {busy, train_done, err, upd_en, fwd_start, act_start, bwd_start}, 0);
    rst = 0;
    @(negedge clk);

    // Minimum-period step with immediate dones, st1=3
    resp_en = 1; fixed_delay = 1; goal_pct = 0; scr = {4'd3};
    pulse_start();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      chk("ctrl_seq", controller, seq[i]);
      if (upd_en) n++;
      @(negedge clk);
    end
    chk("seq_upd_count", n, 1);
    chk("seq_st", st, 3);
    chk("seq_step", step, 1);
    chk("seq_ctrl_back_fwd", controller, 1);
    do_reset();

    // Goal reached on step 2 of episode 0
    resp_en = 1; fixed_delay = 1; scr = {4'd3, 4'd5, 4'd15};
    pulse_start();
    n = 0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(negedge clk);
      if (upd_en) n++;
    end
    chk("goal_upd_seen", n, 3);
    @(negedge clk);
    chk("goal_in_next", controller, 5);
    @(negedge clk);
    chk("goal_episode", episode, 1);
    chk("goal_step", step, 0);
    chk("goal_st", st, INIT);
    chk("goal_ctrl", controller, 1);
    do_reset();

    // Random handshake timing with goals, run to completion
    resp_en = 1; fixed_delay = 0; goal_pct = 20; scr.delete();
    pulse_start();
    wait_done(20000, -1, "runA_reach_done");
    check_done_state("runA");

    // Restart from DONE, no goals: every episode ends at MAX_STEP
    goal_pct = 0;
    pulse_start();
    chk("restart_episode", episode, 0);
    chk("restart_train_done", train_done, 0);
    chk("restart_ctrl", controller, 1);
    wait_done(20000, 60, "runB_reach_done");
    check_done_state("runB");
    do_reset();

    // Reset during BWD; stray start/fwd_done ignored in BWD
    start = 1; @(negedge clk); start = 0;
    chk("man_fwd_start", fwd_start, 1);
    @(negedge clk); fwd_done = 1;
    @(negedge clk); fwd_done = 0;
    chk("man_act_start", act_start, 1);
    @(negedge clk); st1 = 4'd7; act_done = 1;
    @(negedge clk); act_done = 0;
    chk("man_bwd_start", bwd_start, 1);
    chk("man_in_bwd", controller, 3);
    start = 1; fwd_done = 1;
    @(negedge clk);
    start = 0; fwd_done = 0;
    chk("bwd_ignores_stray", controller, 3);
    chk("bwd_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("midrst_ctrl", controller, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_upd", upd_en, 0);
    chk("midrst_counters", {st, step, episode}, {INIT, 4'd0, 12'd0});
    @(negedge clk); rst = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", controller, 0);

    // Withheld act_done: trap to ERR with the watchdog, wait otherwise
    start = 1; @(negedge clk); start = 0;
    @(negedge clk); fwd_done = 1;
    @(negedge clk); fwd_done = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_in_act", controller, 2);
      @(negedge clk);
    end
`ifdef DQN_SEQ_TIMEOUT_EN
    chk("tmo_ctrl_err", controller, 7);
    chk("tmo_err", err, 1);
    repeat (5) @(negedge clk);
    start = 1; @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("tmo_err_sticky", {err, controller}, {1'b1, 4'd7});
`else
    repeat (16) @(negedge clk);
    chk("stall_still_act", controller, 2);
    chk("stall_err_zero", err, 0);
`endif
    do_reset();
    chk("final_idle", {err, controller}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
